fizz_buzz_arbiter: RTL

- Shares one FIZZ_BUZZ generator between NUM_REQ requesters.
- Each requester submits a maximum count. The arbiter grants requesters round-robin, loads the generator through its sink handshake, then forwards the generator's output stream tagged with the requester ID.
- End of job is detected as the source value equal to the requested count, or by a watchdog timeout.
- Sits between the requester agents and the FIZZ_BUZZ instance.

---
 rtl/fizz_buzz_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/fizz_buzz_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fizz_buzz_pkg.sv
// Shared definitions for the FIZZ_BUZZ arbiter slice: default data width,
// controller state encoding and FizzBuzz selector bit positions.
package fizz_buzz_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned FB_W       = 3;

  // Selector bit positions on the generator's FIZZBUZZ output
  localparam int unsigned FIZZ     = 0;
  localparam int unsigned BUZZ     = 1;
  localparam int unsigned FIZZBUZZ = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
//   req   - request vector
//   ptr   - highest-priority index for this search
//   grant - one-hot grant
//   idx   - binary index of the granted requester
//   any   - at least one request is asserted
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  int unsigned pos;

  // Rotating priority search; the first hit wins
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = (32'(ptr) + k) % NUM_REQ;
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fizz_buzz_arbiter.sv
// Shares one FIZZ_BUZZ generator between NUM_REQ requesters. Jobs are granted
// round-robin, loaded into the generator over its sink handshake, and the
// generator's output stream is forwarded tagged with the owner's ID.
//   CLK, RESET_n          - clock, async active-low reset
//   REQ_VALID/DATA/READY  - per-requester job request, max count, accept strobe
//   FB_SINK_*             - generator load handshake
//   FB_SOURCE_*           - generator output stream
//   OUT_*                 - tagged output stream, OUT_LAST marks job end
//   ERR_TIMEOUT           - one-cycle pulse on watchdog abort
//   BUSY                  - controller is not IDLE
module fizz_buzz_arbiter
  import fizz_buzz_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned DATA_W      = DATA_W_DEF,
  parameter  int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
  input  logic                      CLK,
  input  logic                      RESET_n,
  input  logic [NUM_REQ-1:0]        REQ_VALID,
  input  logic [NUM_REQ*DATA_W-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]        REQ_READY,
  input  logic                      FB_SINK_READY,
  output logic                      FB_SINK_VALID,
  output logic [DATA_W-1:0]         FB_SINK_DATA,
  input  logic                      FB_SOURCE_VALID,
  input  logic [DATA_W-1:0]         FB_SOURCE_DATA,
  input  logic [FB_W-1:0]           FB_SOURCE_FIZZBUZZ,
  output logic                      OUT_VALID,
  output logic [ID_W-1:0]           OUT_ID,
  output logic [DATA_W-1:0]         OUT_DATA,
  output logic [FB_W-1:0]           OUT_FIZZBUZZ,
  output logic                      OUT_LAST,
  output logic                      ERR_TIMEOUT,
  output logic                      BUSY
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC);

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, id_q;
  logic [DATA_W-1:0]   count_q;
  logic [WD_W-1:0]     wd_q;

  logic [NUM_REQ-1:0]  gnt_onehot;
  logic [ID_W-1:0]     gnt_idx;
  logic                gnt_any;
  logic [DATA_W-1:0]   req_sel;
  logic [ID_W-1:0]     ptr_next;
  logic                accept;
  logic                src_match;
  logic                wd_expire;

  logic [NUM_REQ-1:0]  req_ready_c;
  logic                sink_valid_d;
  logic                out_valid_d;
  logic                out_last_d;
  logic                err_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (REQ_VALID),
    .ptr   (ptr_q),
    .grant (gnt_onehot),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign req_sel   = REQ_DATA[32'(gnt_idx) * DATA_W +: DATA_W];
  assign ptr_next  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  assign accept    = (state_q == IDLE) && gnt_any;
  assign src_match = FB_SOURCE_VALID && (FB_SOURCE_DATA == count_q);
  // Abort on the idle cycle that would bring the watchdog to TIMEOUT_CYC-1
  assign wd_expire = (state_q == RUN) && !FB_SOURCE_VALID &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 2));

  // State register
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (gnt_any && (req_sel != '0)) state_d = ISSUE;
      ISSUE:   if (FB_SINK_READY) state_d = RUN;
      RUN:     if (src_match || wd_expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode and next values of the registered outputs
  always_comb begin
    req_ready_c  = '0;
    sink_valid_d = 1'b0;
    out_valid_d  = 1'b0;
    out_last_d   = 1'b0;
    err_d        = 1'b0;
    if (state_q == IDLE) req_ready_c = gnt_onehot;
    sink_valid_d = (state_d == ISSUE);
    if (state_q == RUN) begin
      out_valid_d = FB_SOURCE_VALID;
      out_last_d  = src_match;
      err_d       = wd_expire;
    end
  end

  assign REQ_READY    = req_ready_c;
  assign FB_SINK_DATA = count_q;
  assign BUSY         = (state_q != IDLE);

  // Job capture, watchdog and forwarding registers
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      ptr_q         <= '0;
      id_q          <= '0;
      count_q       <= '0;
      wd_q          <= '0;
      FB_SINK_VALID <= 1'b0;
      OUT_VALID     <= 1'b0;
      OUT_ID        <= '0;
      OUT_DATA      <= '0;
      OUT_FIZZBUZZ  <= '0;
      OUT_LAST      <= 1'b0;
      ERR_TIMEOUT   <= 1'b0;
    end else begin
      if (accept) begin
        count_q <= req_sel;
        id_q    <= gnt_idx;
        ptr_q   <= ptr_next;
      end
      // Held at zero outside RUN, so entry to RUN always starts from zero
      if (state_q != RUN || FB_SOURCE_VALID) wd_q <= '0;
      else                                   wd_q <= wd_q + WD_W'(1);
      if (state_q == RUN && FB_SOURCE_VALID) begin
        OUT_ID       <= id_q;
        OUT_DATA     <= FB_SOURCE_DATA;
        OUT_FIZZBUZZ <= FB_SOURCE_FIZZBUZZ;
      end
      FB_SINK_VALID <= sink_valid_d;
      OUT_VALID     <= out_valid_d;
      OUT_LAST      <= out_last_d;
      ERR_TIMEOUT   <= err_d;
    end
  end

endmodule
